mem_bus_if: RTL and testbench
=============================

# mem_bus_if

Memory bus interface sitting directly downstream of the CPU controller. Converts the controller's level strobes (`sel`, `rd`, `wr`, `data_e`) plus the PC, IR operand address and accumulator data into single, cleanly framed memory transactions with programmable wait states and a `mem_ready` handshake. Returns registered read data to the instruction register / ALU and reports `busy` so the sequencer can be stalled.

## Interface
- `AW`, 5, address width (PC and IR operand field)
- `DW`, 8, data width
- `WAIT_CYCLES`, 1, minimum cycles an access is held before `mem_ready` is honoured (0–15)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `sel`  in  1  address source: 1 = `pc_addr`, 0 = `ir_addr`
- `rd`  in  1  read request level from controller
- `wr`  in  1  write request level from controller
- `data_e`  in  1  accumulator data enable (write qualifier)
- `pc_addr`  in  AW  program counter
- `ir_addr`  in  AW  IR operand address field
- `ac_data`  in  DW  accumulator output
- `mem_addr`  out  AW  registered memory address
- `mem_rd_en`  out  1  memory read strobe
- `mem_wr_en`  out  1  memory write strobe
- `mem_wdata`  out  DW  registered write data
- `mem_rdata`  in  DW  memory read data
- `mem_ready`  in  1  memory completes access this cycle
- `rd_data`  out  DW  captured read data, held until next read completes
- `rd_valid`  out  1  one-cycle pulse: `rd_data` updated
- `busy`  out  1  transaction in progress (state ≠ IDLE)
- `coll_err`  out  1  sticky: `rd` and `wr` rose on the same edge

## Operation
- `rd_q`, `wr_q` register the previous strobe levels; a request is a rising edge (`rd & ~rd_q`, `wr & ~wr_q`). Held levels never start a second access.
- FSM states IDLE, ACCESS, DONE.
- IDLE: on write edge with `data_e`=1 → ACCESS, write. Write edge with `data_e`=0 → ignored. Else on read edge → ACCESS, read. Edges arriving while not IDLE are dropped.
- Simultaneous read and write edges: write wins, `coll_err` set.
- Entering ACCESS: latch `mem_addr` = `sel ? pc_addr : ir_addr`, latch `mem_wdata` = `ac_data` (write only), assert `mem_rd_en` or `mem_wr_en`, load `cnt` = `WAIT_CYCLES`.
- ACCESS: if `cnt` ≠ 0, decrement. If `cnt` = 0 and `mem_ready`: read captures `mem_rdata` into `rd_data`; → DONE. Otherwise remain (no timeout).
- DONE: strobes deasserted, `rd_valid` high for reads only; → IDLE next edge.
- `mem_addr`, `mem_wdata` held stable for the whole ACCESS state.

## Timing
- All outputs registered. Reset values: `mem_addr`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_wdata`=0, `rd_data`=0, `rd_valid`=0, `busy`=0, `coll_err`=0; state IDLE, `cnt`=0, `rd_q`=`wr_q`=0.
- Request sampled at edge E0; strobe and address visible after E0; capture at edge E0+`WAIT_CYCLES`+1 with `mem_ready` high; `rd_valid` high for the following cycle; `busy` low again after E0+`WAIT_CYCLES`+2.
- `WAIT_CYCLES`=0: capture at E0+1.
- `mem_ready` low at the eligible edge extends ACCESS one cycle per low sample.
- `rst_n` low mid-transaction: strobes drop immediately (asynchronous), transaction discarded, no `rd_valid`.

## Configuration
- `MEM_BUS_IF_PARITY_EN` defined: adds input `mem_rpar` (1) and output `par_err` (1, reset 0). On each read capture, `par_err` set if `^mem_rdata != mem_rpar` (even parity); sticky until reset; `rd_data` still updated.
- Undefined: ports absent, no parity logic.

## Test plan
- Read, `WAIT_CYCLES`=1, `mem_ready`=1, `sel`=1, `pc_addr`=5'h0A, `mem_rdata`=8'h5C: `mem_addr`=0A, capture 2 edges after request, `rd_data`=5C, `rd_valid` one cycle.
- Write, `sel`=0, `ir_addr`=5'h1F, `ac_data`=8'hA5, `data_e`=1: `mem_wr_en` for 2 cycles, `mem_addr`=1F, `mem_wdata`=A5; no `rd_valid`.
- `mem_ready` low 3 cycles after `cnt` reaches 0: ACCESS extended 3 cycles, `mem_addr` stable, capture on first high sample.
- `rd` and `wr` rise together (`data_e`=1): write performed, `coll_err`=1 and stays 1; `rd` held high 8 cycles produces no second access.
- `rst_n` pulsed low during ACCESS: `mem_rd_en`=0 and `busy`=0 immediately, `rd_data`=0, no `rd_valid`.
- With `MEM_BUS_IF_PARITY_EN`: `mem_rdata`=8'h03, `mem_rpar`=1 → `par_err`=1; `mem_rpar`=0 on fresh reset → `par_err`=0.

Source files
------------

// File: rtl/mem_bus_if_if.sv
// Bundle of controller-side and memory-side signals around mem_bus_if.
// Latency: none (wires only).
// Backpressure: carried by mem_ready; busy lets the controller stall.
// Optional parity signals exist only when MEM_BUS_IF_PARITY_EN is defined.
interface mem_bus_if_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  // controller side
  logic          sel;
  logic          rd;
  logic          wr;
  logic          data_e;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] ir_addr;
  logic [DW-1:0] ac_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          coll_err;
  // memory side
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef MEM_BUS_IF_PARITY_EN
  logic          mem_rpar;
  logic          par_err;
`endif

  // bus interface block view
  modport master (
    input  sel, rd, wr, data_e, pc_addr, ir_addr, ac_data, mem_rdata, mem_ready,
`ifdef MEM_BUS_IF_PARITY_EN
    input  mem_rpar,
    output par_err,
`endif
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, rd_data, rd_valid, busy, coll_err
  );

  // controller + memory view
  modport slave (
    output sel, rd, wr, data_e, pc_addr, ir_addr, ac_data, mem_rdata, mem_ready,
`ifdef MEM_BUS_IF_PARITY_EN
    output mem_rpar,
    input  par_err,
`endif
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata, rd_data, rd_valid, busy, coll_err
  );
endinterface

// File: rtl/mem_bus_if.sv
// Turns controller rd/wr level strobes into single framed memory accesses.
// Latency: strobe after request edge; capture WAIT_CYCLES+1 edges later; rd_valid next cycle.
// Backpressure: mem_ready low at an eligible edge extends the access; edges while busy are dropped.
// Optional feature macro: MEM_BUS_IF_PARITY_EN (adds mem_rpar input, sticky par_err output).
module mem_bus_if #(
  parameter int AW          = 5,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_bus_if_if.master   bus
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          busy_q, busy_d;
  logic          coll_err_q, coll_err_d;
`ifdef MEM_BUS_IF_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  logic rd_rise, wr_rise;

  // Requests are rising edges only, so a held level never starts a second access.
  assign rd_rise = bus.rd & ~rd_q;
  assign wr_rise = bus.wr & ~wr_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_en_d = mem_rd_en_q;
    mem_wr_en_d = mem_wr_en_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    coll_err_d  = coll_err_q;
`ifdef MEM_BUS_IF_PARITY_EN
    par_err_d   = par_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (rd_rise && wr_rise) begin
          coll_err_d = 1'b1;
        end
        if (wr_rise && bus.data_e) begin
          // write wins over a simultaneous read edge
          state_d     = ACCESS;
          mem_wr_en_d = 1'b1;
          mem_addr_d  = bus.sel ? bus.pc_addr : bus.ir_addr;
          mem_wdata_d = bus.ac_data;
          cnt_d       = CW'(WAIT_CYCLES);
        end else if (rd_rise) begin
          state_d     = ACCESS;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = bus.sel ? bus.pc_addr : bus.ir_addr;
          cnt_d       = CW'(WAIT_CYCLES);
        end
      end

      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (bus.mem_ready) begin
          if (mem_rd_en_q) begin
            rd_data_d  = bus.mem_rdata;
            rd_valid_d = 1'b1;
`ifdef MEM_BUS_IF_PARITY_EN
            if ((^bus.mem_rdata) != bus.mem_rpar) begin
              par_err_d = 1'b1;
            end
`endif
          end
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, strobe history and all outputs; reset drops strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      coll_err_q  <= 1'b0;
`ifdef MEM_BUS_IF_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_q        <= bus.rd;
      wr_q        <= bus.wr;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      coll_err_q  <= coll_err_d;
`ifdef MEM_BUS_IF_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.coll_err  = coll_err_q;
`ifdef MEM_BUS_IF_PARITY_EN
  assign bus.par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_mem_bus_if.sv
// Randomized scoreboard bench for mem_bus_if: stimulus pushes expected transaction
// timelines, a negedge monitor compares every DUT output against them each cycle.
module tb_mem_bus_if;
  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int WAIT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_if_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_if #(.AW(AW), .DW(DW), .WAIT_CYCLES(WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected transaction: strobe high for edges [t0, t0+dur-1], DONE at t0+dur.
  typedef struct {
    bit            is_wr;
    bit            coll;
    bit            par_bad;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            t0;
    int            dur;
  } exp_t;

  exp_t          q[$];
  exp_t          act;
  bit            act_vld = 1'b0;
  bit            mon_en  = 1'b0;
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] last_rd = '0;
  bit            coll_exp = 1'b0;
  bit            par_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic restart_model();
    q.delete();
    act_vld  = 1'b0;
    last_rd  = '0;
    coll_exp = 1'b0;
    par_exp  = 1'b0;
  endtask

  // Monitor: compare DUT outputs to the expected timeline every cycle.
  always @(negedge clk) begin
    bit strobe_exp, done_exp;
    if (mon_en) begin
      if (!act_vld && q.size() > 0 && q[0].t0 == cyc) begin
        act     = q.pop_front();
        act_vld = 1'b1;
        if (act.coll) coll_exp = 1'b1;
      end
      strobe_exp = act_vld && (cyc < act.t0 + act.dur);
      done_exp   = act_vld && (cyc == act.t0 + act.dur);
      if (done_exp && !act.is_wr) begin
        last_rd = act.data;
        if (act.par_bad) par_exp = 1'b1;
      end
      chk("busy",      32'(bus.busy),      32'(act_vld));
      chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(strobe_exp && !act.is_wr));
      chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(strobe_exp && act.is_wr));
      chk("rd_valid",  32'(bus.rd_valid),  32'(done_exp && !act.is_wr));
      chk("rd_data",   32'(bus.rd_data),   32'(last_rd));
      chk("coll_err",  32'(bus.coll_err),  32'(coll_exp));
`ifdef MEM_BUS_IF_PARITY_EN
      chk("par_err",   32'(bus.par_err),   32'(par_exp));
`endif
      if (strobe_exp) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(act.addr));
        if (act.is_wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(act.data));
      end
      if (done_exp) act_vld = 1'b0;
    end
  end

  // kind: 0 read, 1 write, 2 read+write together, 3 write with data_e low (ignored).
  // Called right after a negedge with the DUT idle and rd/wr low.
  task automatic do_txn(input int kind, input bit sel, input logic [AW-1:0] pc,
                        input logic [AW-1:0] ir, input logic [DW-1:0] ac,
                        input logic [DW-1:0] rdata, input int stalls, input int hold,
                        input bit again, input bit par_flip);
    exp_t e;
    int   dur;
    dur = WAIT + stalls + 1;
    if (kind == 3 || hold + 1 > dur) again = 1'b0;
    bus.sel       = sel;
    bus.pc_addr   = pc;
    bus.ir_addr   = ir;
    bus.ac_data   = ac;
    bus.mem_rdata = rdata;
    bus.data_e    = (kind != 3);
    bus.mem_ready = 1'b0;
`ifdef MEM_BUS_IF_PARITY_EN
    bus.mem_rpar  = (^rdata) ^ par_flip;
`endif
    bus.rd = (kind == 0 || kind == 2);
    bus.wr = (kind != 0);
    if (kind != 3) begin
      e.is_wr   = (kind != 0);
      e.coll    = (kind == 2);
      e.par_bad = par_flip && (kind == 0);
      e.addr    = sel ? pc : ir;
      e.data    = (kind == 0) ? rdata : ac;
      e.t0      = cyc + 1;
      e.dur     = dur;
      q.push_back(e);
    end
    for (int k = 1; (k <= dur + 2) || (k <= hold + 2); k++) begin
      @(negedge clk);
      if (k == hold) begin
        bus.rd = 1'b0;
        bus.wr = 1'b0;
      end
      if (again && k == hold + 1) bus.rd = 1'b1;
      if (again && k == hold + 2) bus.rd = 1'b0;
      if (k == WAIT + stalls + 1) bus.mem_ready = 1'b1;
    end
  endtask

  task automatic rand_txn();
    int kind;
    kind = $urandom_range(0, 9);
    kind = (kind < 4) ? 0 : (kind < 7) ? 1 : (kind < 9) ? 2 : 3;
    do_txn(kind, 1'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
           $urandom_range(0, 3), $urandom_range(1, 6), 1'($urandom), ($urandom_range(0, 3) == 0));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    restart_model();
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.sel = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.data_e = 1'b0;
    bus.pc_addr = '0; bus.ir_addr = '0; bus.ac_data = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b1;
`ifdef MEM_BUS_IF_PARITY_EN
    bus.mem_rpar = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst mem_addr",  32'(bus.mem_addr),  0);
    chk("rst mem_rd_en", 32'(bus.mem_rd_en), 0);
    chk("rst mem_wr_en", 32'(bus.mem_wr_en), 0);
    chk("rst mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst rd_data",   32'(bus.rd_data),   0);
    chk("rst busy",      32'(bus.busy),      0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);

    // directed cases
    do_txn(0, 1'b1, 5'h0A, 5'h03, 8'h00, 8'h5C, 0, 1, 1'b0, 1'b0);
    do_txn(1, 1'b0, 5'h11, 5'h1F, 8'hA5, 8'h00, 0, 1, 1'b0, 1'b0);
    do_txn(0, 1'b0, 5'h02, 5'h15, 8'h00, 8'h9E, 3, 2, 1'b1, 1'b0);
    do_txn(2, 1'b1, 5'h07, 5'h08, 8'h3C, 8'h77, 0, 8, 1'b0, 1'b0);
    do_txn(3, 1'b0, 5'h04, 5'h05, 8'hFF, 8'h00, 0, 2, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) rand_txn();

    repeat (3) @(negedge clk);
    chk("queue drained", 32'(q.size()), 0);
    chk("no open txn",   32'(act_vld),  0);

    // asynchronous reset in the middle of a read
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    @(negedge clk);
    bus.sel = 1'b1; bus.pc_addr = 5'h13; bus.mem_rdata = 8'hE7;
    bus.mem_ready = 1'b0; bus.rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre-rst mem_rd_en", 32'(bus.mem_rd_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst mem_rd_en", 32'(bus.mem_rd_en), 0);
    chk("arst busy",      32'(bus.busy),      0);
    chk("arst rd_data",   32'(bus.rd_data),   0);
    chk("arst coll_err",  32'(bus.coll_err),  0);
    bus.rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-rst rd_valid", 32'(bus.rd_valid), 0);
      chk("post-rst busy",     32'(bus.busy),     0);
    end
    @(posedge clk);
    #1;
    restart_model();
    mon_en = 1'b1;
    @(negedge clk);

`ifdef MEM_BUS_IF_PARITY_EN
    do_txn(0, 1'b1, 5'h01, 5'h00, 8'h00, 8'h03, 0, 1, 1'b0, 1'b1);
    chk("par_err set", 32'(bus.par_err), 1);
    pulse_reset();
    do_txn(0, 1'b1, 5'h01, 5'h00, 8'h00, 8'h03, 0, 1, 1'b0, 1'b0);
    chk("par_err clear", 32'(bus.par_err), 0);
`else
    pulse_reset();
    do_txn(0, 1'b0, 5'h00, 5'h1E, 8'h00, 8'h81, 1, 1, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
